// File: rtl/dma_word_counter.sv
// Up/down word counter for the DMA generator: reload register, terminal-count
// compare, run/stop control with wrap, stop and auto-reload end-of-transfer modes.
module dma_word_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             enable,
  input  logic             carry_in,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count_out,
  output logic             carry_out,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  logic             step_s;
  logic             hit_s;
  logic [WIDTH-1:0] nxt_s;

  assign step_s = enable & carry_in & (state_q == S_RUN);
  assign nxt_s  = up ? (count_q + ONE) : (count_q - ONE);
  // Only a step that lands on term counts; a count already sitting on term does not.
  assign hit_s  = step_s & (nxt_s == term);

  // Next-state and datapath selection: load > start > step.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = data_in;
      reload_d = data_in;
      state_d  = start ? S_RUN : S_IDLE;
    end else if (start && (state_q != S_RUN)) begin
      state_d = S_RUN;
    end else if (hit_s) begin
      tc_d = 1'b1;
      case (mode)
        2'b00: begin
          count_d = nxt_s;
        end
        2'b10: begin
          count_d = reload_q;
        end
        default: begin
          count_d = nxt_s;
          state_d = S_DONE;
        end
      endcase
    end else if (step_s) begin
      count_d = nxt_s;
    end else begin
      count_d = count_q;
    end
  end

  // State, count, reload and terminal-count pulse registers.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q  <= S_IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign carry_out = step_s & (up ? (count_q == ONES) : (count_q == ZERO));

endmodule

// File: doc/dma_word_counter.md
Name: dma_word_counter

Overview:
Parametrised up/down word counter for the Am2940-style DMA generator. It generalises the 4-bit cascadable counter slice to WIDTH bits and adds a reload register, a terminal-count compare, and a run/stop state machine with three end-of-transfer modes. It sits beside the address counter and reports the end of a transfer with `tc` and `done`. Its carry chain remains cascadable, so the same stepping drives the address slices.

Parameters:
WIDTH, 16, counter, reload register and terminal-compare width (minimum 2)

Ports:
clk  input  1  single clock; all state updates on its rising edge
res_n  input  1  reset, synchronous, active-low
load  input  1  load data_in into counter and reload register
data_in  input  WIDTH  load value
start  input  1  arm counting (IDLE/DONE -> RUN)
enable  input  1  count enable
carry_in  input  1  cascade carry in; a step needs enable and carry_in both high
up  input  1  1 = increment, 0 = decrement
mode  input  2  00 wrap, 01 stop at terminal, 10 auto-reload at terminal, 11 treated as 01
term  input  WIDTH  terminal count value
count_out  output  WIDTH  registered count
carry_out  output  1  combinational cascade carry out
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  high while in DONE state
busy  output  1  high while in RUN state

Behaviour:
- Clock and reset: one clock, `clk`. Reset `res_n` is synchronous and active-low.
- Reset (`res_n` = 0 at an edge): count_out = 0, reload register = 0, state = IDLE, tc = 0, done = 0, busy = 0. Reset overrides every other input.
- States and outputs:
  - IDLE: no counting.
  - RUN: counting permitted; busy = 1.
  - DONE: counting halted; done = 1.
  - busy and done are decoded from registered state (no extra latency).
- Priority per edge: reset > load > start > step.
- `step` = enable & carry_in & (state == RUN).
- `nxt` = up ? count_out + 1 : count_out - 1, modulo 2^WIDTH (wraps: max -> 0 up, 0 -> max down).
- Load:
  - count_out <= data_in, reload register <= data_in, tc <= 0. Allowed in any state.
  - With start also high: state <= RUN. Otherwise state <= IDLE.
- Start (no load): IDLE or DONE -> RUN. Count is unchanged. Start during RUN is ignored.
- Terminal hit = step & (nxt == term). A count already equal to term when start is asserted does not hit; only a step that lands on term does.
- On a step with no hit: count_out <= nxt, tc <= 0.
- On a hit, tc <= 1 for exactly one cycle, then by mode:
  - 00: count_out <= nxt; state stays RUN.
  - 01/11: count_out <= nxt (= term); state <= DONE. Further enable/carry_in has no effect until start or load.
  - 10: count_out <= reload register (not term); state stays RUN.
- tc is 0 in every cycle not directly following a hit.
- carry_out = step & (up ? count_out == all-ones : count_out == 0). It is 0 outside RUN and is combinational from the current count.
- mode, up and term are sampled at every step; a change takes effect on the next step.
- Reset mid-RUN: next cycle all outputs at their reset values.

Test Plan:
- WIDTH = 8 is used for all scenarios below.
- Reset: res_n = 0 for 2 cycles with load = 1, data_in = 8'hAA -> count_out = 0, tc = done = busy = 0; async-style glitch on res_n between edges has no effect.
- Mode 01 up: load 8'h05, start, term = 8'h08, enable = carry_in = 1 -> count 06, 07, 08; tc high the cycle count = 08; done = 1, busy = 0; count holds 08 for 5 further cycles.
- Mode 10 down: load 8'h03, term = 8'h00, start, step continuously -> 02, 01, then 03 with one tc pulse; repeats every 3 steps; busy stays 1.
- Mode 00 wrap and carry: load 8'hFE, term = 8'h10, up, start -> carry_out = 1 only while count = FF and stepping; count FF -> 00 -> 01; tc = 0 throughout; carry_in = 0 stalls the count and forces carry_out = 0.
- Priority: load 8'h20 and start in the same cycle during RUN -> count = 20, state RUN, tc = 0. Start with no load in DONE -> RUN from the held count. Load alone in RUN -> IDLE, no steps taken.
- Reset mid-run: RUN at count 8'h44, res_n = 0 for one edge -> count 00, IDLE, busy = 0; stepping inputs are ignored until start.
